zrb_uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares a single `zrb_uart_tx` instance between four byte-stream requesters. For each grant it optionally emits a channel-tag header byte, then up to `MAX_BURST` data bytes from the granted channel before re-arbitrating. It sits between the requesters and the transmitter's `write`/`data`/`busy` pins. `zrb_baud_generator` and `zrb_uart_tx` stay external.

---
 rtl/zrb_uart_tx_arbiter.sv | 120 ++++++++++++
 tb/tb_zrb_uart_tx_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zrb_uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between four byte-stream
// requesters; each grant sends an optional channel-tag header then a bounded burst.
module zrb_uart_tx_arbiter #(
   parameter bit HEADER_EN = 1'b1,
   parameter int MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  req_valid,
   input  logic [31:0] req_data,
   output logic [3:0]  req_ready,
   input  logic        tx_busy,
   output logic        tx_write,
   output logic [7:0]  tx_data,
   output logic [3:0]  grant,
   output logic        active
);

   typedef enum logic [2:0] {IDLE, HDR, HDR_WAIT, DATA, DATA_WAIT} state_t;

   localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

   state_t     state;
   state_t     state_nx;
   logic [1:0] ch;
   logic [1:0] ch_sel;
   logic [1:0] ptr;
   logic       sel_found;
   logic [3:0] burst_cnt;
   logic [7:0] last_byte;
   logic [7:0] ch_byte;
   logic [1:0] idx;

   assign ch_byte = req_data[{ch, 3'b000} +: 8];

   // Search ptr+1, ptr+2, ptr+3, ptr; the last step wraps back to ptr itself.
   always_comb begin
      ch_sel    = ptr;
      sel_found = 1'b0;
      idx       = ptr;
      for (int unsigned k = 1; k <= 4; k++) begin
         idx = ptr + 2'(k);
         if (!sel_found && req_valid[idx]) begin
            ch_sel    = idx;
            sel_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (sel_found) state_nx = HEADER_EN ? HDR : DATA;
         HDR:       if (tx_busy) state_nx = HDR_WAIT;
         HDR_WAIT:  if (!tx_busy) state_nx = req_valid[ch] ? DATA : IDLE;
         DATA:      if (tx_busy) state_nx = DATA_WAIT;
         DATA_WAIT: if (!tx_busy)
                       state_nx = (req_valid[ch] && (burst_cnt < BURST_MAX)) ? DATA : IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ch        <= '0;
         ptr       <= 2'd3;
         burst_cnt <= '0;
         grant     <= '0;
         req_ready <= '0;
         last_byte <= '0;
      end else begin
         req_ready <= '0;
         if (tx_write) last_byte <= tx_data;
         case (state)
            IDLE: if (sel_found) begin
               ch        <= ch_sel;
               grant     <= 4'b0001 << ch_sel;
               burst_cnt <= '0;
            end
            HDR_WAIT: if (!tx_busy && !req_valid[ch]) begin
               ptr   <= ch;
               grant <= '0;
            end
            DATA: if (tx_busy) begin
               req_ready <= 4'b0001 << ch;
               burst_cnt <= burst_cnt + 4'd1;
            end
            DATA_WAIT: if (state_nx == IDLE) begin
               ptr   <= ch;
               grant <= '0;
            end
            default: ;
         endcase
      end
   end

   // Outside HDR/DATA the line data holds the last byte offered to the transmitter.
   always_comb begin
      tx_write = 1'b0;
      tx_data  = last_byte;
      active   = (state != IDLE);
      case (state)
         HDR: begin
            tx_write = 1'b1;
            tx_data  = {4'hA, 2'b00, ch};
         end
         DATA: begin
            tx_write = 1'b1;
            tx_data  = ch_byte;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_zrb_uart_tx_arbiter.sv
// Randomized bench: queue-based requesters, a behavioural UART transmitter
// (with occasional dropped writes) and a scoreboard of expected line bytes.
module tb_zrb_uart_tx_arbiter;

   localparam int MAXB = 3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_busy;
   logic        tx_write;
   logic [7:0]  tx_data;
   logic [3:0]  grant;
   logic        active;

   zrb_uart_tx_arbiter #(.HEADER_EN(1'b1), .MAX_BURST(MAXB)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_busy(tx_busy), .tx_write(tx_write),
      .tx_data(tx_data), .grant(grant), .active(active)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [7:0] b; logic [1:0] c;} exp_t;
   exp_t expq[$];
   int   compared = 0;
   int   mismatched = 0;

   logic [7:0] mem [4][16];
   logic [3:0] head [4];
   logic [3:0] tail [4];
   logic [3:0] hdr_only = '0;
   logic [3:0] pend_pop = '0;
   int         ready_obs [4];
   int         pushed [4];
   int         mptr = 3;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         req_valid[i]       = (head[i] != tail[i]) || hdr_only[i];
         req_data[8*i +: 8] = mem[i][head[i]];
      end
   end

   // Transmitter: loads on a write while idle (unless dropping), busy next cycle.
   logic       ld_valid;
   logic [7:0] ld_byte;
   logic [3:0] ld_grant;
   int         busy_left;
   int         drop_left;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_busy <= 1'b0; busy_left <= 0; drop_left <= 0;
         ld_valid <= 1'b0; ld_byte <= '0; ld_grant <= '0;
      end else begin
         ld_valid <= 1'b0;
         if (tx_busy) begin
            if (busy_left <= 1) tx_busy <= 1'b0;
            busy_left <= busy_left - 1;
         end else if (tx_write) begin
            if (drop_left > 0) drop_left <= drop_left - 1;
            else begin
               tx_busy   <= 1'b1;
               busy_left <= int'($urandom_range(3, 8));
               ld_valid  <= 1'b1;
               ld_byte   <= tx_data;
               ld_grant  <= grant;
               drop_left <= ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
         end
      end
   end

   // Monitor: every byte the transmitter accepts is compared with the scoreboard.
   initial begin
      logic prev_w;
      logic acc;
      exp_t e;
      prev_w = 1'b0;
      acc = 1'b0;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (tx_write && !prev_w) acc = 1'b0;
            if (ld_valid) begin
               acc = 1'b1;
               compared++;
               if (expq.size() == 0) begin
                  mismatched++;
                  $display("FAIL line_byte: got %02h grant %b, expected nothing", ld_byte, ld_grant);
               end else begin
                  e = expq.pop_front();
                  if (ld_byte !== e.b || ld_grant !== (4'b0001 << e.c)) begin
                     mismatched++;
                     $display("FAIL line_byte: got %02h grant %b, expected %02h grant %b",
                              ld_byte, ld_grant, e.b, 4'b0001 << e.c);
                  end
               end
            end
            if (req_ready != 4'b0000) begin
               compared++;
               if (req_ready !== grant) begin
                  mismatched++;
                  $display("FAIL ready_owner: req_ready %b, expected grant %b", req_ready, grant);
               end
            end
            if (!tx_write && prev_w) begin
               compared++;
               if (!acc) begin
                  mismatched++;
                  $display("FAIL write_hold: tx_write fell with accepted=%0d, expected 1", acc);
               end
            end
            prev_w = tx_write;
         end else begin
            prev_w = 1'b0;
            acc = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (pend_pop[i]) begin
            head[i] = head[i] + 4'd1;
            pend_pop[i] = 1'b0;
         end
         if (req_ready[i]) begin
            pend_pop[i] = 1'b1;
            ready_obs[i]++;
         end
         if (ld_valid && hdr_only[i] && ld_grant[i]) hdr_only[i] = 1'b0;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_write"}, 32'(tx_write), 32'd0);
      check({tag, "_tx_data"}, 32'(tx_data), 32'h00);
      check({tag, "_grant"}, 32'(grant), 32'd0);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_active"}, 32'(active), 32'd0);
   endtask

   task automatic clear_state();
      expq.delete();
      for (int i = 0; i < 4; i++) begin
         head[i] = '0; tail[i] = '0; ready_obs[i] = 0; pushed[i] = 0;
      end
      hdr_only = '0;
      pend_pop = '0;
      mptr = 3;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      clear_state();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Reference: whole-batch byte stream from the round-robin and burst rules.
   task automatic load_batch();
      int n [4];
      int pos [4];
      bit ho [4];
      bit ho_orig [4];
      int c;
      int take;
      bit found;
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         head[i] = '0; tail[i] = '0; pos[i] = 0;
         n[i] = int'($urandom_range(0, 5));
         ho[i] = (n[i] == 0) && ($urandom_range(0, 2) == 0);
      end
      if (n[0] + n[1] + n[2] + n[3] == 0 && !(ho[0] || ho[1] || ho[2] || ho[3])) begin
         c = int'($urandom_range(0, 3));
         n[c] = int'($urandom_range(1, 5));
      end
      for (int i = 0; i < 4; i++) begin
         ho_orig[i] = ho[i];
         for (int j = 0; j < n[i]; j++) mem[i][j] = 8'($urandom_range(0, 255));
      end
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         c = 0;
         for (int k = 1; k <= 4; k++) begin
            if (!found && (n[(mptr + k) % 4] > pos[(mptr + k) % 4] || ho[(mptr + k) % 4])) begin
               c = (mptr + k) % 4;
               found = 1'b1;
            end
         end
         if (found) begin
            e.b = 8'hA0 | 8'(c);
            e.c = 2'(c);
            expq.push_back(e);
            if (ho[c]) ho[c] = 1'b0;
            else begin
               take = (n[c] - pos[c] > MAXB) ? MAXB : n[c] - pos[c];
               for (int j = 0; j < take; j++) begin
                  e.b = mem[c][pos[c] + j];
                  expq.push_back(e);
               end
               pos[c] += take;
            end
            mptr = c;
         end
      end
      for (int i = 0; i < 4; i++) begin
         tail[i] = 4'(n[i]);
         hdr_only[i] = ho_orig[i];
         pushed[i] += n[i];
      end
   endtask

   task automatic drain(output bit ok);
      int budget;
      budget = 4000;
      ok = 1'b0;
      while (budget > 0 && !ok) begin
         tick();
         budget--;
         ok = (expq.size() == 0) && (hdr_only == 4'b0000) && !tx_busy &&
              (head[0] == tail[0]) && (head[1] == tail[1]) &&
              (head[2] == tail[2]) && (head[3] == tail[3]);
      end
   endtask

   initial begin
      bit ok;
      int budget;
      clear_state();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 16; j++) mem[i][j] = '0;
      @(posedge clk);
      #1;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      for (int b = 0; b < 40; b++) begin
         load_batch();
         tick();
         check("grant_latency_write", 32'(tx_write), 32'd1);
         check("grant_latency_grant", 32'(grant), 32'(4'b0001 << expq[0].c));
         if (b % 8 == 5) begin
            budget = 2000;
            while (budget > 0 && req_ready == 4'b0000) begin
               tick();
               budget--;
            end
            if (budget == 0) begin
               compared++;
               mismatched++;
               $display("FAIL ready_wait: no req_ready within 2000 cycles, expected a pulse");
            end
            do_reset();
         end else begin
            drain(ok);
            if (!ok) begin
               compared++;
               mismatched++;
               $display("FAIL drain_timeout: %0d bytes still pending, expected 0", expq.size());
               do_reset();
            end else begin
               repeat (3) tick();
               check("idle_grant", 32'(grant), 32'd0);
               check("idle_active", 32'(active), 32'd0);
               check("idle_write", 32'(tx_write), 32'd0);
               for (int i = 0; i < 4; i++)
                  check($sformatf("ready_count_ch%0d", i), 32'(ready_obs[i]), 32'(pushed[i]));
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
